// File: rtl/ram_arbitrated_if.sv
// Bus bundle for ram_arbitrated: the CPU data bus, the debug req/ack
// channel, write protect and the fill-in-progress flag.
interface ram_arbitrated_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    // CPU bus
    logic              cpu_en;
    logic [ADDR_W-1:0] addr;
    logic              RW;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              wp;

    // Debug channel
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    // Status
    logic              busy;

    // Drives the bus: CPU side and debugger
    modport master (
        output cpu_en, addr, RW, data_in, wp,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  data_out, data_oe, dbg_ack, dbg_rdata, busy
    );

    // The RAM itself
    modport slave (
        input  cpu_en, addr, RW, data_in, wp,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output data_out, data_oe, dbg_ack, dbg_rdata, busy
    );
endinterface

// File: rtl/ram_arbitrated.sv
// Single-port system RAM shared between the CPU bus and a debug unit.
// The CPU has fixed priority; debug accesses fill idle cycles through a
// req/ack handshake. Optional post-reset fill and a CPU write-protect mode.
module ram_arbitrated #(
    parameter int                ADDR_W         = 16,
    parameter int                DATA_W         = 8,
    parameter int                DEPTH_LOG2     = 14,
    parameter logic [ADDR_W-1:0] BASE           = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_W-1:0] FILL           = '0
) (
    input  logic              mem_clk,
    input  logic              rst_n,
    ram_arbitrated_if.slave   bus
);

    localparam int                    DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [ADDR_W-1:0]     BASE_TAG = BASE >> DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;
    localparam logic [DEPTH_LOG2-1:0] ONE_IDX  = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t                state_reg, state_next;
    logic [DEPTH_LOG2-1:0] fill_cnt_reg, fill_cnt_next;
    logic                  cpu_rd_reg, cpu_rd_next;
    logic                  dbg_ack_reg;
    logic                  dbg_rd_reg, dbg_rd_next;

    logic                  cpu_sel, dbg_sel, cpu_hit, dbg_gnt;

    // Single array port, shared by fill, CPU and debug
    logic                  mem_we, mem_re;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_array [DEPTH];
    logic [DATA_W-1:0]     ram_q;

    assign cpu_sel = (bus.addr >> DEPTH_LOG2) == BASE_TAG;
    assign dbg_sel = (bus.dbg_addr >> DEPTH_LOG2) == BASE_TAG;
    assign cpu_hit = bus.cpu_en & cpu_sel;

    // A grant needs an idle array and is never issued in an ack cycle,
    // so a request still held during its ack is not served twice.
    assign dbg_gnt = (state_reg == ST_RUN) & bus.dbg_req & ~cpu_hit & ~dbg_ack_reg;

    // Next state and array port arbitration: fill, then CPU, then debug
    always_comb begin
        state_next    = state_reg;
        fill_cnt_next = fill_cnt_reg;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_idx       = bus.addr[DEPTH_LOG2-1:0];
        mem_wdata     = bus.data_in;
        cpu_rd_next   = 1'b0;
        dbg_rd_next   = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                mem_we        = 1'b1;
                mem_idx       = fill_cnt_reg;
                mem_wdata     = FILL;
                fill_cnt_next = fill_cnt_reg + ONE_IDX;
                if (fill_cnt_reg == LAST_IDX) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cpu_hit) begin
                    if (bus.RW) begin
                        mem_re      = 1'b1;
                        cpu_rd_next = 1'b1;
                    end else begin
                        mem_we = ~bus.wp;
                    end
                end else if (dbg_gnt && dbg_sel) begin
                    mem_idx   = bus.dbg_addr[DEPTH_LOG2-1:0];
                    mem_wdata = bus.dbg_wdata;
                    if (bus.dbg_we) begin
                        mem_we = 1'b1;
                    end else begin
                        mem_re      = 1'b1;
                        dbg_rd_next = 1'b1;
                    end
                end
            end
            default: state_next = RESET_STATE;
        endcase
    end

    // Control state; reset abandons any fill or pending debug transaction
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RESET_STATE;
            fill_cnt_reg <= '0;
            cpu_rd_reg   <= 1'b0;
            dbg_ack_reg  <= 1'b0;
            dbg_rd_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fill_cnt_reg <= fill_cnt_next;
            cpu_rd_reg   <= cpu_rd_next;
            dbg_ack_reg  <= dbg_gnt;
            dbg_rd_reg   <= dbg_rd_next;
        end
    end

    // Storage with registered read; kept free of reset so it maps to block RAM
    always_ff @(posedge mem_clk) begin
        if (mem_we) begin
            mem_array[mem_idx] <= mem_wdata;
        end
        if (mem_re) begin
            ram_q <= mem_array[mem_idx];
        end
    end

    // The read register is shared, so each consumer sees it only when the
    // previous cycle's read was its own; otherwise it reads as zero.
    assign bus.data_oe   = cpu_rd_reg;
    assign bus.data_out  = cpu_rd_reg ? ram_q : '0;
    assign bus.dbg_ack   = dbg_ack_reg;
    assign bus.dbg_rdata = dbg_rd_reg ? ram_q : '0;
    assign bus.busy      = (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_ram_arbitrated.sv
// Directed bench for ram_arbitrated: a 16-word instance with fill enabled
// and a 16K-word instance without fill, driven from one linear sequence.
module tb_ram_arbitrated;

    logic mem_clk;
    logic rst_n_a;
    logic rst_n_b;

    int n_tests = 0;
    int n_fail  = 0;

    ram_arbitrated_if #(.ADDR_W(16), .DATA_W(8)) ia ();
    ram_arbitrated_if #(.ADDR_W(16), .DATA_W(8)) ib ();

    ram_arbitrated #(
        .ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(4), .BASE(16'h0000),
        .CLEAR_ON_RESET(1'b1), .FILL(8'hA5)
    ) dut_a (
        .mem_clk (mem_clk),
        .rst_n   (rst_n_a),
        .bus     (ia)
    );

    ram_arbitrated #(
        .ADDR_W(16), .DATA_W(8), .DEPTH_LOG2(14), .BASE(16'h0000),
        .CLEAR_ON_RESET(1'b0), .FILL(8'h00)
    ) dut_b (
        .mem_clk (mem_clk),
        .rst_n   (rst_n_b),
        .bus     (ib)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) begin
            $display("[TB] %-16s obs=%b", tag, obs);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) begin
            $display("[TB] %-16s obs=%h", tag, obs);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) begin
            $display("[TB] %-16s obs=%0d", tag, obs);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts cycles until busy falls (bounded), trying a CPU read and a CPU
    // write to index 1 while the fill is running; both must be ignored.
    task automatic fill_a(output int cyc, output bit oe_seen, output bit ack_seen);
        cyc      = 0;
        oe_seen  = 1'b0;
        ack_seen = 1'b0;
        while (cyc < 100) begin
            tick();
            cyc++;
            if (ia.data_oe) oe_seen = 1'b1;
            if (ia.dbg_ack) ack_seen = 1'b1;
            if (!ia.busy) break;
            if (cyc == 3) begin
                ia.cpu_en = 1'b1; ia.RW = 1'b1; ia.addr = 16'h0002;
            end
            if (cyc == 5) begin
                ia.RW = 1'b0; ia.addr = 16'h0001; ia.data_in = 8'h5A;
            end
            if (cyc == 6) ia.cpu_en = 1'b0;
        end
    endtask

    initial begin
        int  cyc;
        bit  oe_seen;
        bit  ack_seen;

        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        ia.cpu_en = 1'b0; ia.addr = '0; ia.RW = 1'b1; ia.data_in = '0; ia.wp = 1'b0;
        ia.dbg_req = 1'b0; ia.dbg_we = 1'b0; ia.dbg_addr = '0; ia.dbg_wdata = '0;
        ib.cpu_en = 1'b0; ib.addr = '0; ib.RW = 1'b1; ib.data_in = '0; ib.wp = 1'b0;
        ib.dbg_req = 1'b0; ib.dbg_we = 1'b0; ib.dbg_addr = '0; ib.dbg_wdata = '0;

        // ---- reset values ----
        repeat (3) tick();
        chk_byte("a_rst_data_out", ia.data_out, 8'h00);
        chk_bit ("a_rst_data_oe",  ia.data_oe, 1'b0);
        chk_bit ("a_rst_dbg_ack",  ia.dbg_ack, 1'b0);
        chk_byte("a_rst_dbg_rdata", ia.dbg_rdata, 8'h00);
        chk_bit ("a_rst_busy",     ia.busy, 1'b1);
        chk_bit ("b_rst_busy",     ib.busy, 1'b0);
        chk_bit ("b_rst_data_oe",  ib.data_oe, 1'b0);

        // ---- fill: 16 busy cycles, debug read held throughout ----
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        ia.dbg_req = 1'b1; ia.dbg_we = 1'b0; ia.dbg_addr = 16'h0005;
        fill_a(cyc, oe_seen, ack_seen);
        chk_int("a_fill_cycles", cyc, 16);
        chk_bit("a_fill_no_oe",  oe_seen, 1'b0);
        chk_bit("a_fill_no_ack", ack_seen, 1'b0);
        // first RUN cycle grants the held request; ack follows
        tick();
        chk_bit ("a_dbg_ack",   ia.dbg_ack, 1'b1);
        chk_byte("a_dbg_rdata", ia.dbg_rdata, 8'hA5);
        ia.dbg_req = 1'b0;
        tick();
        chk_bit("a_dbg_ack_end", ia.dbg_ack, 1'b0);

        // ---- read back all 16 words, each with a one-cycle data_oe ----
        for (int i = 0; i < 16; i++) begin
            ia.cpu_en = 1'b1; ia.RW = 1'b1; ia.addr = 16'(i);
            tick();
            chk_bit ("a_rb_oe",   ia.data_oe, 1'b1);
            chk_byte("a_rb_data", ia.data_out, 8'hA5);
            ia.cpu_en = 1'b0;
            tick();
            chk_bit ("a_rb_oe_off", ia.data_oe, 1'b0);
        end

        // ---- asynchronous reset while data_oe is high ----
        ia.cpu_en = 1'b1; ia.RW = 1'b1; ia.addr = 16'h0007;
        tick();
        chk_bit("a_pre_rst_oe", ia.data_oe, 1'b1);
        ia.cpu_en = 1'b0;
        rst_n_a = 1'b0;
        #1;
        chk_bit ("a_async_oe",   ia.data_oe, 1'b0);
        chk_byte("a_async_data", ia.data_out, 8'h00);
        chk_bit ("a_async_busy", ia.busy, 1'b1);
        tick();
        tick();

        // ---- reset at fill cycle 7, then a full refill ----
        rst_n_a = 1'b1;
        repeat (7) tick();
        chk_bit("a_midfill_busy", ia.busy, 1'b1);
        rst_n_a = 1'b0;
        #1;
        chk_bit("a_midrst_busy", ia.busy, 1'b1);
        chk_bit("a_midrst_ack",  ia.dbg_ack, 1'b0);
        tick();
        tick();
        rst_n_a = 1'b1;
        fill_a(cyc, oe_seen, ack_seen);
        chk_int("a_refill_cycles", cyc, 16);
        chk_bit("a_refill_no_oe",  oe_seen, 1'b0);
        ia.cpu_en = 1'b1; ia.RW = 1'b1; ia.addr = 16'h0001;
        tick();
        chk_byte("a_refill_idx1", ia.data_out, 8'hA5);
        ia.cpu_en = 1'b0;
        tick();

        // ---- CPU write/read and window decode ----
        ib.cpu_en = 1'b1; ib.RW = 1'b0; ib.addr = 16'h1234; ib.data_in = 8'h3C;
        tick();
        ib.RW = 1'b1;
        tick();
        chk_bit ("b_rd1234_oe",   ib.data_oe, 1'b1);
        chk_byte("b_rd1234_data", ib.data_out, 8'h3C);
        ib.addr = 16'h4000;
        tick();
        chk_bit("b_rd4000_oe", ib.data_oe, 1'b0);
        ib.cpu_en = 1'b0;
        tick();
        chk_bit("b_idle_oe", ib.data_oe, 1'b0);

        // ---- write protect: CPU writes dropped, debug write lands ----
        ib.wp = 1'b1;
        ib.cpu_en = 1'b1; ib.RW = 1'b0; ib.addr = 16'h0010; ib.data_in = 8'hFF;
        tick();
        ib.cpu_en = 1'b0;
        ib.dbg_req = 1'b1; ib.dbg_we = 1'b1; ib.dbg_addr = 16'h0010; ib.dbg_wdata = 8'h77;
        tick();
        chk_bit ("b_dbgwr_ack",   ib.dbg_ack, 1'b1);
        chk_byte("b_dbgwr_rdata", ib.dbg_rdata, 8'h00);
        ib.dbg_req = 1'b0;
        tick();
        chk_bit("b_dbgwr_ack_end", ib.dbg_ack, 1'b0);
        ib.cpu_en = 1'b1; ib.RW = 1'b0; ib.addr = 16'h0010; ib.data_in = 8'hFF;
        tick();
        ib.RW = 1'b1;
        tick();
        chk_bit ("b_wp_rd_oe",   ib.data_oe, 1'b1);
        chk_byte("b_wp_rd_data", ib.data_out, 8'h77);
        ib.cpu_en = 1'b0;
        ib.wp = 1'b0;
        tick();

        // ---- arbitration: CPU holds the array for 5 cycles ----
        ib.dbg_req = 1'b1; ib.dbg_we = 1'b0; ib.dbg_addr = 16'h0010;
        ib.cpu_en = 1'b1; ib.RW = 1'b1; ib.addr = 16'h0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_bit("b_arb_no_ack", ib.dbg_ack, 1'b0);
            chk_bit("b_arb_cpu_oe", ib.data_oe, 1'b1);
        end
        ib.cpu_en = 1'b0;
        // first idle cycle grants, the ack is visible after that edge
        tick();
        chk_bit ("b_arb_ack",   ib.dbg_ack, 1'b1);
        chk_byte("b_arb_rdata", ib.dbg_rdata, 8'h77);
        ib.dbg_req = 1'b0;
        tick();
        chk_bit("b_arb_ack_end", ib.dbg_ack, 1'b0);

        // ---- held request: no grant in the ack cycle ----
        ib.dbg_req = 1'b1; ib.dbg_we = 1'b0; ib.dbg_addr = 16'h1234;
        tick();
        chk_bit ("b_b2b_ack1",   ib.dbg_ack, 1'b1);
        chk_byte("b_b2b_rdata1", ib.dbg_rdata, 8'h3C);
        tick();
        chk_bit ("b_b2b_gap",    ib.dbg_ack, 1'b0);
        tick();
        chk_bit ("b_b2b_ack2",   ib.dbg_ack, 1'b1);
        chk_byte("b_b2b_rdata2", ib.dbg_rdata, 8'h3C);
        ib.dbg_req = 1'b0;
        tick();

        // ---- debug outside the window: acked, zero data, no write ----
        ib.dbg_req = 1'b1; ib.dbg_we = 1'b0; ib.dbg_addr = 16'h8000;
        tick();
        chk_bit ("b_out_rd_ack",   ib.dbg_ack, 1'b1);
        chk_byte("b_out_rd_rdata", ib.dbg_rdata, 8'h00);
        ib.dbg_req = 1'b0;
        tick();
        ib.dbg_req = 1'b1; ib.dbg_we = 1'b1; ib.dbg_addr = 16'h8010; ib.dbg_wdata = 8'hEE;
        tick();
        chk_bit ("b_out_wr_ack",   ib.dbg_ack, 1'b1);
        chk_byte("b_out_wr_rdata", ib.dbg_rdata, 8'h00);
        ib.dbg_req = 1'b0;
        tick();
        // CPU write outside the window must not alias onto index 0x10 either
        ib.cpu_en = 1'b1; ib.RW = 1'b0; ib.addr = 16'h4010; ib.data_in = 8'h11;
        tick();
        ib.RW = 1'b1; ib.addr = 16'h0010;
        tick();
        chk_bit ("b_unchanged_oe",   ib.data_oe, 1'b1);
        chk_byte("b_unchanged_data", ib.data_out, 8'h77);
        ib.cpu_en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
